// File: rtl/alu_seg_display.sv
// Display stage for the 8-bit ALU: latches result+carry, converts to BCD, scans a 4-digit 7-seg display.
// Latency: result visible on the display registers 8 clk after the load edge (1 clk in hex mode).
// Backpressure: busy is high during a conversion; load while busy is dropped (no queuing).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (priority over all inputs)
//   value[7:0], carry ALU result and carry-out, captured when load is seen in IDLE
//   load              capture/convert request
//   hex_sel           (only with ALU_SEG_HEX_MODE_EN) show value as two hex digits instead
//   busy              conversion in progress
//   an[3:0]           active-low one-hot anodes, an[0] = ones digit
//   seg[6:0]          active-low segments g..a, dp active-low (always off)
// Optional feature macro: ALU_SEG_HEX_MODE_EN.
module alu_seg_display #(
    parameter int DIV_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       carry,
    input  logic       load,
`ifdef ALU_SEG_HEX_MODE_EN
    input  logic       hex_sel,
`endif
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [11:0]          bcd_q, bcd_d;
    logic [2:0]           step_q, step_d;
    logic                 pcarry_q, pcarry_d;
    logic                 hex_q, hex_d;
    logic [3:0]           disp_h_q, disp_h_d;
    logic [3:0]           disp_t_q, disp_t_d;
    logic [3:0]           disp_o_q, disp_o_d;
    logic                 disp_c_q, disp_c_d;
    logic                 disp_hex_q, disp_hex_d;
    logic [DIV_BITS-1:0]  cnt_q, cnt_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 hex_sel_w;
    logic [11:0]          bcd_adj;
    logic [19:0]          dd_shift;
    logic [1:0]           sel;

`ifdef ALU_SEG_HEX_MODE_EN
    assign hex_sel_w = hex_sel;
`else
    assign hex_sel_w = 1'b0;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
`ifdef ALU_SEG_HEX_MODE_EN
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            4'hF:    glyph = 7'b0001110;
`endif
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_shift = {bcd_adj, shift_q} << 1;
    end

    // Conversion FSM and display registers.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        pcarry_d   = pcarry_q;
        hex_d      = hex_q;
        disp_h_d   = disp_h_q;
        disp_t_d   = disp_t_q;
        disp_o_d   = disp_o_q;
        disp_c_d   = disp_c_q;
        disp_hex_d = disp_hex_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d  = value;
                    pcarry_d = carry;
                    hex_d    = hex_sel_w;
                    bcd_d    = '0;
                    step_d   = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                if (hex_q) begin
                    // Hex mode bypasses the converter: raw nibbles go straight out.
                    disp_h_d   = 4'd0;
                    disp_t_d   = shift_q[7:4];
                    disp_o_d   = shift_q[3:0];
                    disp_c_d   = pcarry_q;
                    disp_hex_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    bcd_d   = dd_shift[19:8];
                    shift_d = dd_shift[7:0];
                    step_d  = step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        // Commit the post-step value so it is visible on this same edge.
                        disp_h_d   = dd_shift[19:16];
                        disp_t_d   = dd_shift[15:12];
                        disp_o_d   = dd_shift[11:8];
                        disp_c_d   = pcarry_q;
                        disp_hex_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan: an and seg both come from the next counter value and next display
    // contents, so the registered outputs always agree with each other.
    always_comb begin
        cnt_d = cnt_q + DIV_BITS'(1);
        sel   = cnt_d[DIV_BITS-1 -: 2];
        an_d  = ~(4'b0001 << sel);
        seg_d = SEG_BLANK;
        case (sel)
            2'd0: seg_d = glyph(disp_o_d);
            2'd1: seg_d = (!disp_hex_d && disp_h_d == 4'd0 && disp_t_d == 4'd0)
                          ? SEG_BLANK : glyph(disp_t_d);
            2'd2: seg_d = (disp_h_d == 4'd0) ? SEG_BLANK : glyph(disp_h_d);
            2'd3: seg_d = disp_c_d ? SEG_ONE : SEG_BLANK;
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            pcarry_q   <= 1'b0;
            hex_q      <= 1'b0;
            disp_h_q   <= '0;
            disp_t_q   <= '0;
            disp_o_q   <= '0;
            disp_c_q   <= 1'b0;
            disp_hex_q <= 1'b0;
            cnt_q      <= '0;
            an_q       <= 4'b1110;
            seg_q      <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            pcarry_q   <= pcarry_d;
            hex_q      <= hex_d;
            disp_h_q   <= disp_h_d;
            disp_t_q   <= disp_t_d;
            disp_o_q   <= disp_o_d;
            disp_c_q   <= disp_c_d;
            disp_hex_q <= disp_hex_d;
            cnt_q      <= cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy = (state_q == CONV);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_alu_seg_display.sv
// Bench for alu_seg_display with DIV_BITS=4: directed vector table plus
// hand-written sequences for reset, busy timing, ignored loads and aborts.
module tb_alu_seg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       carry;
    logic       load;
`ifdef ALU_SEG_HEX_MODE_EN
    logic       hex_sel;
`endif
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;

    alu_seg_display #(.DIV_BITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .carry (carry),
        .load  (load),
`ifdef ALU_SEG_HEX_MODE_EN
        .hex_sel(hex_sel),
`endif
        .busy  (busy),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       c;
        logic [6:0] d0, d1, d2, d3;
    } vec_t;

    vec_t vecs[9];

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the scan to reach digit d, then compare its segments.
    task automatic chk_digit(input string name, input int d, input logic [6:0] exp);
        logic [3:0] target;
        bit         found;
        target = ~(4'b0001 << d);
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (an == target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            chk({name, "_scan_timeout"}, {28'd0, an}, {28'd0, target});
        end else begin
            chk(name, {25'd0, seg}, {25'd0, exp});
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic c);
        value = v;
        carry = c;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'd255, 1'b0, S5, S5, S2, SB};
        vecs[1] = '{8'd7,   1'b0, S7, SB, SB, SB};
        vecs[2] = '{8'd4,   1'b1, S4, SB, SB, S1};
        vecs[3] = '{8'd100, 1'b0, S0, S0, S1, SB};
        vecs[4] = '{8'd0,   1'b0, S0, SB, SB, SB};
        vecs[5] = '{8'd10,  1'b1, S0, S1, SB, S1};
        vecs[6] = '{8'd209, 1'b0, S9, S0, S2, SB};
        vecs[7] = '{8'd38,  1'b0, S8, S3, SB, SB};
        vecs[8] = '{8'd166, 1'b1, S6, S6, S1, S1};

        rst   = 1'b1;
        value = '0;
        carry = 1'b0;
        load  = 1'b0;
`ifdef ALU_SEG_HEX_MODE_EN
        hex_sel = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state and scan stepping
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dp",   {31'd0, dp},   32'd1);
        chk("rst_an",   {28'd0, an},   32'b1110);
        chk("rst_seg",  {25'd0, seg},  {25'd0, S0});
        for (int k = 1; k < 4; k++) begin
            repeat (4) tick();
            chk($sformatf("scan_an%0d", k), {28'd0, an}, {28'd0, ~(4'b0001 << k)});
            chk($sformatf("scan_seg%0d", k), {25'd0, seg}, {25'd0, SB});
        end

        // Busy window for a full conversion: high after edges N..N+7, low after N+8
        do_load(8'd255, 1'b0);
        chk("busy_N", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("busy_N+%0d", k), {31'd0, busy}, (k < 8) ? 32'd1 : 32'd0);
        end

        // Vector table
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].v, vecs[i].c);
            repeat (7) tick();
            chk($sformatf("v%0d_busy7", i), {31'd0, busy}, 32'd1);
            tick();
            chk($sformatf("v%0d_busy8", i), {31'd0, busy}, 32'd0);
            chk_digit($sformatf("v%0d_d0", i), 0, vecs[i].d0);
            chk_digit($sformatf("v%0d_d1", i), 1, vecs[i].d1);
            chk_digit($sformatf("v%0d_d2", i), 2, vecs[i].d2);
            chk_digit($sformatf("v%0d_d3", i), 3, vecs[i].d3);
        end

        // Load while busy is dropped
        do_load(8'd255, 1'b0);
        tick();
        tick();
        do_load(8'd100, 1'b0);          // lands on edge N+3
        repeat (5) tick();              // now after N+8
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk_digit("ign_d0", 0, S5);
        chk_digit("ign_d1", 1, S5);
        chk_digit("ign_d2", 2, S2);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        // Load held high restarts as soon as IDLE is reached
        value = 8'd5;
        carry = 1'b0;
        load  = 1'b1;
        tick();
        repeat (8) tick();
        chk("hold_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("hold_restart", {31'd0, busy}, 32'd1);
        load = 1'b0;
        repeat (8) tick();
        chk("hold_done", {31'd0, busy}, 32'd0);
        chk_digit("hold_d0", 0, S5);

        // Reset aborts a conversion at N+4
        do_load(8'd99, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_an",   {28'd0, an},   32'b1110);
        chk("abort_seg",  {25'd0, seg},  {25'd0, S0});
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_busy_late", {31'd0, busy}, 32'd0);
        chk_digit("abort_d0", 0, S0);
        chk_digit("abort_d1", 1, SB);

        // Reset and load on the same edge: reset wins, nothing captured
        value = 8'd255;
        carry = 1'b1;
        load  = 1'b1;
        rst   = 1'b1;
        tick();
        load  = 1'b0;
        rst   = 1'b0;
        chk("rl_busy", {31'd0, busy}, 32'd0);
        repeat (10) tick();
        chk("rl_busy_late", {31'd0, busy}, 32'd0);
        chk_digit("rl_d0", 0, S0);
        chk_digit("rl_d3", 3, SB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
